// File: rtl/range_sequencer_if.sv
// Purpose: bundles the sample-load, start and consumer-side signals of range_sequencer.
// Ports (master = producer/driver side, slave = range_sequencer):
//   wr_en, wr_data, start                         -> toward the sequencer
//   go, finish, data_out                          <- consumer strobes and sample
//   count, busy, done, start_err, overflow        <- status
interface range_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic             start_err;
    logic             overflow;

    modport master (
        output wr_en, wr_data, start,
        input  go, finish, data_out, count, busy, done, start_err, overflow
    );

    modport slave (
        input  wr_en, wr_data, start,
        output go, finish, data_out, count, busy, done, start_err, overflow
    );
endinterface

// File: rtl/range_sequencer.sv
// Purpose: buffers samples in a circular store and, on start, emits the whole
// buffered burst one sample per cycle with go/finish strobes on first/last.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset (priority over wr_en/start)
//   bus    - range_sequencer_if.slave: wr_en/wr_data/start in;
//            go/finish/data_out/count/busy/done/start_err/overflow out (all registered)
module range_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    range_sequencer_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    remain_q, remain_d;
    logic [CW-1:0]    count_eff_c;
    logic             mem_we_c;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_err_q, start_err_d;
    logic             overflow_q, overflow_d;

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remain_d    = remain_q;
        count_eff_c = count_q;
        mem_we_c    = 1'b0;
        go_d        = 1'b0;
        finish_d    = 1'b0;
        data_d      = data_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        start_err_d = 1'b0;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.wr_en) begin
                    if (count_q == CW'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we_c    = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PW'(1);
                        count_eff_c = count_q + CW'(1);
                    end
                end
                count_d = count_eff_c;
                // A same-edge write counts toward the burst; the oldest sample
                // is already in the store because at least one was buffered.
                if (bus.start) begin
                    if (count_eff_c >= CW'(2)) begin
                        state_d  = SEND;
                        go_d     = 1'b1;
                        busy_d   = 1'b1;
                        data_d   = mem_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        count_d  = count_eff_c - CW'(1);
                        remain_d = count_eff_c - CW'(1);
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.wr_en) begin
                    overflow_d = 1'b1;
                end
                // remain_q counts samples still to present after the current one
                if (remain_q != CW'(0)) begin
                    data_d   = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d  = count_q - CW'(1);
                    remain_d = remain_q - CW'(1);
                    busy_d   = 1'b1;
                    finish_d = (remain_q == CW'(1));
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (bus.wr_en) begin
                    overflow_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remain_q    <= '0;
            go_q        <= 1'b0;
            finish_q    <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remain_q    <= remain_d;
            go_q        <= go_d;
            finish_q    <= finish_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Sample store; contents need no reset since pointers and count are cleared
    always_ff @(posedge clock) begin
        if (mem_we_c && !reset) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.go        = go_q;
    assign bus.finish    = finish_q;
    assign bus.data_out  = data_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.start_err = start_err_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_range_sequencer.sv
// Purpose: self-checking bench for range_sequencer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_range_sequencer;
    localparam int unsigned W = 8;
    localparam int unsigned D = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    range_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    range_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer is a queue; k = position in burst
    // (0 idle, 1..n presenting sample k, n+1 done cycle).
    logic [W-1:0] q[$];
    int           k = 0;
    int           n = 0;
    logic         m_valid = 1'b0;
    logic         m_go, m_fin, m_busy, m_done, m_serr, m_ovf;
    logic [W-1:0] m_data;
    int           m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            k = 0; n = 0;
            m_go = 0; m_fin = 0; m_busy = 0; m_done = 0; m_serr = 0; m_ovf = 0;
            m_data = '0; m_cnt = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_serr = 0;
            if (k == 0) begin
                if (bus.wr_en) begin
                    if (q.size() < D) q.push_back(bus.wr_data);
                    else m_ovf = 1;
                end
                if (bus.start) begin
                    if (q.size() >= 2) begin
                        n = q.size();
                        k = 1;
                    end else begin
                        m_serr = 1;
                    end
                end
            end else begin
                if (bus.wr_en) m_ovf = 1;
                if (k == n + 1) k = 0;
                else k++;
            end
            m_go = 0; m_fin = 0; m_busy = 0;
            if (k >= 1 && k <= n) begin
                m_data = q.pop_front();
                m_go   = (k == 1);
                m_fin  = (k == n);
                m_busy = 1;
            end
            m_done = (k != 0) && (k == n + 1);
            m_cnt  = q.size();
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("go",        32'(bus.go),        32'(m_go));
            check("finish",    32'(bus.finish),    32'(m_fin));
            check("data_out",  32'(bus.data_out),  32'(m_data));
            check("count",     32'(bus.count),     32'(m_cnt));
            check("busy",      32'(bus.busy),      32'(m_busy));
            check("done",      32'(bus.done),      32'(m_done));
            check("start_err", 32'(bus.start_err), 32'(m_serr));
            check("overflow",  32'(bus.overflow),  32'(m_ovf));
        end
    end

    task automatic cyc(input logic w, input logic [W-1:0] d, input logic s, input logic r);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.start   = s;
        reset       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    logic [W-1:0] wv [6];
    int           seen;
    int           got_fin;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        reset       = 1'b1;
        do_reset();
        do_reset();

        // Reset state
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_go", 32'(bus.go), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);

        // Three-sample burst
        cyc(1'b1, 8'h05, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        check("b3_count_pre", 32'(bus.count), 32'd3);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("b3_go", 32'(bus.go), 32'd1);
        check("b3_d0", 32'(bus.data_out), 32'h05);
        check("b3_busy", 32'(bus.busy), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("b3_d1", 32'(bus.data_out), 32'h11);
        check("b3_go_low", 32'(bus.go), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("b3_fin", 32'(bus.finish), 32'd1);
        check("b3_d2", 32'(bus.data_out), 32'h02);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("b3_done", 32'(bus.done), 32'd1);
        check("b3_count0", 32'(bus.count), 32'd0);
        check("b3_busy0", 32'(bus.busy), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("b3_done_pulse", 32'(bus.done), 32'd0);
        check("b3_hold", 32'(bus.data_out), 32'h02);

        // Rejected start with a single sample
        do_reset();
        cyc(1'b1, 8'h7F, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("serr", 32'(bus.start_err), 32'd1);
        check("serr_go", 32'(bus.go), 32'd0);
        check("serr_count", 32'(bus.count), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("serr_pulse", 32'(bus.start_err), 32'd0);

        // Write coinciding with start joins the burst
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        check("ws_go", 32'(bus.go), 32'd1);
        check("ws_d0", 32'(bus.data_out), 32'h7F);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("ws_fin", 32'(bus.finish), 32'd1);
        check("ws_d1", 32'(bus.data_out), 32'h33);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Overflow on a full buffer
        do_reset();
        for (int i = 1; i <= 9; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd8);
        cyc(1'b0, '0, 1'b1, 1'b0);
        seen = 0; got_fin = 0;
        for (int i = 0; i < 12 && got_fin == 0; i++) begin
            if (bus.busy) seen++;
            if (bus.finish) begin
                got_fin = 1;
                check("ovf_fin_data", 32'(bus.data_out), 32'h08);
            end
            cyc(1'b0, '0, 1'b0, 1'b0);
        end
        check("ovf_fin_seen", 32'(got_fin), 32'd1);
        check("ovf_n", 32'(seen), 32'd8);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Write during a burst is dropped
        do_reset();
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        check("wdb_ovf", 32'(bus.overflow), 32'd1);
        check("wdb_d1", 32'(bus.data_out), 32'hA2);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("wdb_d2", 32'(bus.data_out), 32'hA3);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("wdb_done", 32'(bus.done), 32'd1);
        check("wdb_count", 32'(bus.count), 32'd0);

        // Reset aborts a burst on its second sample
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("abort_d1", 32'(bus.data_out), 32'h41);
        cyc(1'b1, 8'h99, 1'b1, 1'b1);
        check("abort_data", 32'(bus.data_out), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            check("abort_no_fin", 32'(bus.finish), 32'd0);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end

        // Fill/drain/refill across pointer wrap
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 6; i++) begin
                wv[i] = W'($urandom_range(0, 255));
                cyc(1'b1, wv[i], 1'b0, 1'b0);
            end
            cyc(1'b0, '0, 1'b1, 1'b0);
            for (int i = 0; i < 6; i++) begin
                check("wrap_data", 32'(bus.data_out), 32'(wv[i]));
                cyc(1'b0, '0, 1'b0, 1'b0);
            end
            check("wrap_done", 32'(bus.done), 32'd1);
            cyc(1'b0, '0, 1'b0, 1'b0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 249) == 0));
        end
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/range_sequencer.md
RANGE_SEQUENCER -- requirements
Module: range_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 8, sample buffer depth (power of two, >= 2).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  load wr_data into the sample buffer this cycle.
REQ-006 wr_data  input  WIDTH  sample to load.
REQ-007 start  input  1  request to emit the buffered burst.
REQ-008 go  output  1  first-sample strobe toward the range-finding consumer.
REQ-009 finish  output  1  last-sample strobe toward the consumer.
REQ-010 data_out  output  WIDTH  sample presented to the consumer.
REQ-011 count  output  $clog2(DEPTH)+1  samples currently buffered.
REQ-012 busy  output  1  burst in progress.
REQ-013 done  output  1  one-cycle pulse after the final sample.
REQ-014 start_err  output  1  one-cycle pulse when start is rejected.
REQ-015 overflow  output  1  sticky flag, a write was dropped.

Function
REQ-016 Consumer protocol: go high for exactly one cycle with the first sample; one sample per cycle on data_out; finish high for exactly one cycle with the last sample; go and finish never high together.
REQ-017 FSM states: IDLE, SEND, DONE.
REQ-018 IDLE: go = finish = busy = 0; data_out holds its last value.
REQ-019 IDLE -> SEND when start = 1 and count >= 2; burst length N = count, latched at that edge.
REQ-020 start in IDLE with count < 2: state unchanged, buffer unchanged, start_err = 1 the next cycle.
REQ-021 start in SEND or DONE: ignored, no start_err.
REQ-022 Latency: with start accepted at edge t, go = 1 and data_out = oldest sample in the cycle after t; samples follow in write order at one per cycle; finish = 1 with sample N, N cycles after t.
REQ-023 busy SHALL be 1 in every cycle in which a sample is presented, and 0 otherwise.
REQ-024 SEND -> DONE after sample N is presented; in DONE, done = 1 for exactly one cycle, then -> IDLE.
REQ-025 Each sample presented SHALL be removed from the buffer; count decrements by 1 per presented sample and is 0 in the DONE cycle.
REQ-026 All of go, finish, data_out, busy, done and start_err SHALL be registered outputs.
REQ-027 Write in IDLE with count < DEPTH: sample stored at the tail; count increments.
REQ-028 Write in IDLE with count = DEPTH: sample dropped, count unchanged, overflow set.
REQ-029 Write in SEND or DONE: sample dropped, overflow set.
REQ-030 Write and accepted start at the same edge: the write is stored and the start is accepted; N includes the new sample.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.

Reset
REQ-032 reset SHALL force, at the next edge: state IDLE, count 0, pointers 0, go 0, finish 0, data_out 0, busy 0, done 0, start_err 0, overflow 0.
REQ-033 reset during SEND SHALL abort the burst immediately: no finish and no done are produced, and the buffer contents are discarded.
REQ-034 reset SHALL take priority over wr_en and start at the same edge.

Verification
REQ-035 Write 0x05, 0x11, 0x02, then pulse start: go = 1 with 0x05; next cycle 0x11; next cycle finish = 1 with 0x02; next cycle done = 1, count = 0, busy = 0.
REQ-036 Write 0x7F only, then pulse start: start_err = 1 for one cycle, go stays 0, count stays 1.
REQ-037 With DEPTH = 8, write 9 samples 0x01..0x09, then pulse start: overflow = 1, N = 8, finish = 1 with 0x08.
REQ-038 Write during a burst: overflow = 1, burst output unchanged, count = 0 after done.
REQ-039 Assert reset on the second sample of a 4-sample burst: the next cycle shows all outputs 0 and count 0, and no finish or done follows.
REQ-040 Fill, drain and refill 5 times with 6 samples each (pointer wrap): data_out order matches write order every burst.
